// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding and parameter limits.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  localparam int MIN_HALF  = 4;
  localparam int MAX_WIDTH = 32;
  localparam int TMR_W     = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one WIDTH-bit full-duplex frame per start, MSB first.
//
// state | meaning
// IDLE  | ssel high, waiting for start
// SETUP | ssel low, first bit on mosi, sck low
// HIGH  | sck high; miso sampled on the last cycle
// LOW   | sck low; next bit presented on entry
// GAP   | one half-period hold with ssel low, then two half-periods deselected
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HALF  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sck,
  output logic             ssel,
  output logic             mosi,
  input  logic             miso
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);

  spi_state_t       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [BIT_W-1:0] r_bit;
  logic [1:0]       r_phase;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_busy;
  logic             r_done;
  logic             r_sck;
  logic             r_ssel;
  logic             r_mosi;
  logic             w_miso_sync;
  logic             w_tmr_end;

  sync2 u_sync_miso (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (miso),
    .o_q   (w_miso_sync)
  );

  assign w_tmr_end = (r_tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_bit      <= '0;
      r_phase    <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sck      <= 1'b0;
      r_ssel     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_SETUP;
            r_tmr      <= TMR_LOAD;
            r_bit      <= BIT_LOAD;
            r_tx_shift <= tx_data << 1;
            r_rx_shift <= '0;
            r_mosi     <= tx_data[WIDTH-1];
            r_ssel     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SETUP, ST_LOW: begin
          if (w_tmr_end) begin
            r_state <= ST_HIGH;
            r_tmr   <= TMR_LOAD;
            r_sck   <= 1'b1;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_HIGH: begin
          if (w_tmr_end) begin
            r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_miso_sync};
            r_sck      <= 1'b0;
            r_tmr      <= TMR_LOAD;
            if (r_bit != '0) begin
              r_state    <= ST_LOW;
              r_mosi     <= r_tx_shift[WIDTH-1];
              r_tx_shift <= r_tx_shift << 1;
              r_bit      <= r_bit - BIT_W'(1);
            end else begin
              r_state <= ST_GAP;
              r_phase <= 2'd0;
            end
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (w_tmr_end) begin
            r_tmr <= TMR_LOAD;
            // phase 0 holds ssel low; phases 1-2 keep the slave deselected
            if (r_phase == 2'd0) begin
              r_phase <= 2'd1;
              r_ssel  <= 1'b1;
              r_mosi  <= 1'b0;
            end else if (r_phase == 2'd1) begin
              r_phase <= 2'd2;
            end else begin
              r_state   <= ST_IDLE;
              r_phase   <= 2'd0;
              r_tmr     <= '0;
              r_rx_data <= r_rx_shift;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
            end
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ssel  <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sck     = r_sck;
  assign ssel    = r_ssel;
  assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a 32-bit instance (loopback or slave model) and an 8-bit loopback instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, start8;
  logic [31:0] tx32;
  logic [7:0]  tx8;
  logic        busy32, done32, sck32, ssel32, mosi32, miso32;
  logic [31:0] rx32;
  logic        busy8, done8, sck8, ssel8, mosi8, miso8;
  logic [7:0]  rx8;
  logic        loop_mode;
  logic        s_miso;

  assign miso32 = loop_mode ? mosi32 : s_miso;
  assign miso8  = mosi8;

  spi_master #(.WIDTH(32), .HALF(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .tx_data(tx32), .busy(busy32), .done(done32),
    .rx_data(rx32), .sck(sck32), .ssel(ssel32), .mosi(mosi32), .miso(miso32)
  );

  spi_master #(.WIDTH(8), .HALF(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .busy(busy8), .done(done8),
    .rx_data(rx8), .sck(sck8), .ssel(ssel8), .mosi(mosi8), .miso(miso8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int sck_rises32 = 0;
  int dones32 = 0;
  int dones8 = 0;
  int mosi_viol = 0;

  always @(posedge sck32) sck_rises32++;
  always @(posedge clk) begin
    if (done32 === 1'b1) dones32++;
    if (done8 === 1'b1) dones8++;
  end
  always @(negedge clk) begin
    if (rst === 1'b0 && ((ssel32 && mosi32) || (ssel8 && mosi8))) mosi_viol++;
  end

  // Mode-0 slave: drives its next bit 3 clk after ssel falls and after each sck fall
  logic [31:0] s_word = 32'h0000_1234;
  int  s_idx;
  bit  s_run;
  initial s_miso = 1'b0;
  always begin
    @(negedge ssel32);
    s_idx = 31;
    repeat (3) @(posedge clk);
    #1 s_miso = s_word[s_idx];
    s_idx--;
    s_run = 1'b1;
    while (s_run) begin
      @(negedge sck32 or posedge ssel32);
      if (ssel32) s_run = 1'b0;
      else begin
        repeat (3) @(posedge clk);
        #1;
        if (s_idx >= 0) begin
          s_miso = s_word[s_idx];
          s_idx--;
        end
      end
    end
  end

  int n, fall_at, done_at, base_r, base_d, dn, rise_n, gap;
  logic busy_c1, busy_done, rx_moved, prev_ssel;
  logic [7:0] rx_first;

  initial begin
    rst = 1'b1; start32 = 1'b0; start8 = 1'b1; tx32 = '0; tx8 = 8'hFF; loop_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ssel", {31'd0, ssel32}, 32'd1);
    chk("rst_sck", {31'd0, sck32}, 32'd0);
    chk("rst_mosi", {31'd0, mosi32}, 32'd0);
    chk("rst_busy", {31'd0, busy32}, 32'd0);
    chk("rst_done", {31'd0, done32}, 32'd0);
    chk("rst_rx", rx32, 32'd0);
    chk("rst_start_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_start_ssel8", {31'd0, ssel8}, 32'd1);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("post_rst_busy8", {31'd0, busy8}, 32'd0);

    // 8-bit frame timing: start sampled in cycle 0
    tx8 = 8'h3C; start8 = 1'b1;
    chk("c0_ssel8", {31'd0, ssel8}, 32'd1);
    @(negedge clk);
    start8 = 1'b0;
    n = 1; fall_at = -1; done_at = -1; busy_c1 = 1'b0; busy_done = 1'b1;
    while (n <= 200 && done_at < 0) begin
      if (n == 1) busy_c1 = busy8;
      if (!ssel8 && fall_at < 0) fall_at = n;
      if (done8) begin done_at = n; busy_done = busy8; end
      if (done_at < 0) begin @(negedge clk); n++; end
    end
    chk("ssel_fall_cycle", fall_at, 32'd1);
    chk("done_cycle", done_at, 32'd77);
    chk("busy_cycle1", {31'd0, busy_c1}, 32'd1);
    chk("busy_at_done", {31'd0, busy_done}, 32'd0);
    chk("rx8_loop", {24'd0, rx8}, 32'h3C);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done8}, 32'd0);

    // 32-bit loopback
    loop_mode = 1'b1; base_r = sck_rises32; base_d = dones32;
    tx32 = 32'hA5C3_0F01; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n = 0; rx_moved = 1'b0;
    while (n < 2000 && !done32) begin
      if (rx32 !== 32'd0) rx_moved = 1'b1;
      @(negedge clk); n++;
    end
    chk("rx32_loop", rx32, 32'hA5C3_0F01);
    chk("sck_rises", sck_rises32 - base_r, 32'd32);
    chk("rx_stable", {31'd0, rx_moved}, 32'd0);
    repeat (2) @(negedge clk);
    chk("loop_dones", dones32 - base_d, 32'd1);

    // slave model, with a start pulse and tx change mid-frame
    loop_mode = 1'b0; base_d = dones32;
    tx32 = 32'h1357_9BDF; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n = 1;
    while (n < 2000 && !done32) begin
      if (n == 50) begin start32 = 1'b1; tx32 = 32'hFFFF_FFFF; end
      if (n == 51) start32 = 1'b0;
      @(negedge clk); n++;
    end
    chk("rx32_slave", rx32, 32'h0000_1234);
    repeat (300) @(negedge clk);
    chk("midframe_dones", dones32 - base_d, 32'd1);
    chk("midframe_idle", {31'd0, busy32}, 32'd0);

    // back-to-back with start held high
    base_d = dones8; tx8 = 8'hCA; start8 = 1'b1;
    @(negedge clk);
    n = 0; dn = 0; rise_n = -1; gap = -1; prev_ssel = ssel8; rx_first = '0;
    while (n < 1000 && dn < 2) begin
      if (busy8 && dn == 0) tx8 = 8'hCB;
      if (ssel8 && !prev_ssel) rise_n = n;
      if (!ssel8 && prev_ssel && rise_n >= 0 && gap < 0) gap = n - rise_n;
      if (done8) begin dn++; if (dn == 1) rx_first = rx8; end
      if (dn == 1 && busy8) start8 = 1'b0;
      prev_ssel = ssel8;
      if (dn < 2) begin @(negedge clk); n++; end
    end
    start8 = 1'b0;
    chk("b2b_rx_first", {24'd0, rx_first}, 32'hCA);
    chk("b2b_rx_second", {24'd0, rx8}, 32'hCB);
    chk("b2b_gap_ge4", {31'd0, (gap >= 4)}, 32'd1);
    repeat (2) @(negedge clk);
    chk("b2b_dones", dones8 - base_d, 32'd2);

    // reset after the 5th sck rising edge
    loop_mode = 1'b1; base_r = sck_rises32; tx32 = 32'hFFFF_0000; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n = 0;
    while ((sck_rises32 - base_r) < 5 && n < 500) begin @(negedge clk); n++; end
    chk("abort_sck_reached", {31'd0, sck32}, 32'd1);
    base_d = dones32;
    rst = 1'b1; start32 = 1'b1;
    @(negedge clk);
    chk("abort_ssel", {31'd0, ssel32}, 32'd1);
    chk("abort_sck", {31'd0, sck32}, 32'd0);
    chk("abort_busy", {31'd0, busy32}, 32'd0);
    chk("abort_done", {31'd0, done32}, 32'd0);
    chk("abort_mosi", {31'd0, mosi32}, 32'd0);
    chk("abort_rx", rx32, 32'd0);
    rst = 1'b0; start32 = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_done", dones32 - base_d, 32'd0);
    chk("abort_idle", {31'd0, busy32}, 32'd0);
    chk("mosi_when_deselected", mosi_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
